// File: rtl/cluster_boot_sequencer.sv
// Boot controller: after start and a programmable delay, writes the entry point to the boot-control register, then pulses debug_req.
// Request appears StartDelay+1 cycles after start; payload is held stable under q_ready_i backpressure until accepted or timed out.
module cluster_boot_sequencer #(
  parameter int unsigned          AddrWidth        = 48,
  parameter int unsigned          DataWidth        = 64,
  parameter int unsigned          NumCores         = 4,
  parameter logic [AddrWidth-1:0] BootCtrlAddr     = '0,
  parameter int unsigned          StartDelay       = 1000,
  parameter int unsigned          DebugPulseCycles = 1,
  parameter int unsigned          TimeoutCycles    = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [31:0]            entry_point_i,
  output logic [AddrWidth-1:0]   q_addr_o,
  output logic [DataWidth-1:0]   q_data_o,
  output logic                   q_write_o,
  output logic [DataWidth/8-1:0] q_strb_o,
  output logic                   q_valid_o,
  input  logic                   q_ready_i,
  input  logic                   p_valid_i,
  input  logic                   p_error_i,
  output logic                   p_ready_o,
  output logic [NumCores-1:0]    debug_req_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o
);

  typedef enum logic [2:0] {
    IDLE, DELAY, REQ, RSP, WAKE, DONE, ERROR
  } state_e;

  // Counters hold "remaining cycles minus one", so zero means this is the last cycle.
  localparam logic [31:0] DelayLoad   = (StartDelay == 0) ? 32'd0 : 32'(StartDelay - 1);
  localparam logic [31:0] PulseLoad   = 32'(DebugPulseCycles - 1);
  localparam logic [31:0] TimeoutLast = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);
  localparam bit          TimeoutEn   = (TimeoutCycles != 0);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] entry_q, entry_d;
  logic        timed_out;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    entry_d   = entry_q;
    timed_out = TimeoutEn && (tcnt_q >= TimeoutLast);

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          entry_d = entry_point_i;
          cnt_d   = DelayLoad;
          tcnt_d  = '0;
          state_d = (StartDelay == 0) ? REQ : DELAY;
        end
      end
      DELAY: begin
        if (cnt_q == 0) begin
          tcnt_d  = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q - 1;
        end
      end
      REQ: begin
        if (TimeoutEn) tcnt_d = tcnt_q + 1;
        // An accepted request wins over a timeout landing in the same cycle.
        if (q_ready_i)      state_d = RSP;
        else if (timed_out) state_d = ERROR;
      end
      RSP: begin
        if (TimeoutEn) tcnt_d = tcnt_q + 1;
        if (p_valid_i) begin
          cnt_d   = PulseLoad;
          state_d = p_error_i ? ERROR : WAKE;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      WAKE: begin
        if (cnt_q == 0) state_d = DONE;
        else            cnt_d   = cnt_q - 1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output decodes from registered state; the payload is zero outside REQ.
  assign q_valid_o   = (state_q == REQ);
  assign q_write_o   = q_valid_o;
  assign q_strb_o    = {(DataWidth/8){q_valid_o}};
  assign q_addr_o    = q_valid_o ? BootCtrlAddr : '0;
  assign q_data_o    = q_valid_o ? DataWidth'(entry_q) : '0;
  assign p_ready_o   = (state_q == RSP);
  assign debug_req_o = {NumCores{state_q == WAKE}};
  assign busy_o      = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
  assign done_o      = (state_q == DONE);
  assign error_o     = (state_q == ERROR);

endmodule
